// File: rtl/cache_types.sv
// Shared types for the burst line buffer: read-fill and write-drain FSM states.
package cache_types;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_REQ,
    RD_FILL,
    RD_DONE
  } burst_rd_state_t;

  typedef enum logic [0:0] {
    WB_EMPTY,
    WB_DRAIN
  } burst_wb_state_t;

endpackage

// File: rtl/burst_line_serializer.sv
// One-entry posted write buffer that drains a captured line to memory one beat
// at a time, advancing only on bmem_ready_i.
module burst_line_serializer
  import cache_types::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [LINE_WIDTH-1:0] line_i,
  input  logic                  bmem_ready_i,
  output burst_wb_state_t       state_o,
  output logic                  valid_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [LINE_WIDTH-1:0] line_o,
  output logic                  bmem_write_o,
  output logic [ADDR_WIDTH-1:0] bmem_addr_o,
  output logic [BEAT_WIDTH-1:0] bmem_wdata_o
);

  localparam int NUM_BEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int CNT_W = $clog2(NUM_BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

  burst_wb_state_t       state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] line_q;
  logic                  capture;

  assign capture = load_i && (state_q == WB_EMPTY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WB_EMPTY;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      if (capture) begin
        addr_q <= addr_i;
        line_q <= line_i;
      end
    end
  end

  // A beat is transferred on every cycle where bmem_write_o and bmem_ready_i are both high.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    valid_d      = valid_q;
    bmem_write_o = 1'b0;
    bmem_addr_o  = '0;
    bmem_wdata_o = '0;
    case (state_q)
      WB_EMPTY: begin
        if (capture) begin
          state_d = WB_DRAIN;
          cnt_d   = '0;
          valid_d = 1'b1;
        end
      end
      WB_DRAIN: begin
        bmem_write_o = 1'b1;
        bmem_addr_o  = addr_q;
        bmem_wdata_o = line_q[int'(cnt_q) * BEAT_WIDTH +: BEAT_WIDTH];
        if (bmem_ready_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d = WB_EMPTY;
            valid_d = 1'b0;
          end
        end
      end
      default: state_d = WB_EMPTY;
    endcase
  end

  assign state_o = state_q;
  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign line_o  = line_q;

endmodule

// File: rtl/burst_line_buffer.sv
// Cacheline-to-beat adapter: posted line writes drained by the serializer, line
// reads filled beat by beat, with read forwarding from the pending write buffer.
module burst_line_buffer
  import cache_types::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] l2cache_addr,
  input  logic                  l2cache_read,
  input  logic                  l2cache_write,
  input  logic [LINE_WIDTH-1:0] l2cache_wdata,
  output logic [LINE_WIDTH-1:0] l2cache_rdata,
  output logic                  l2cache_resp,
  output logic [ADDR_WIDTH-1:0] bmem_addr,
  output logic                  bmem_read,
  output logic                  bmem_write,
  output logic [BEAT_WIDTH-1:0] bmem_wdata,
  input  logic                  bmem_ready,
  input  logic [ADDR_WIDTH-1:0] bmem_raddr,
  input  logic [BEAT_WIDTH-1:0] bmem_rdata,
  input  logic                  bmem_rvalid
);

  localparam int NUM_BEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int CNT_W = $clog2(NUM_BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(LINE_WIDTH / 8 - 1);

  burst_rd_state_t       rd_state_q, rd_state_d;
  logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
  logic [LINE_WIDTH-1:0] rd_line_q, rd_line_d;
  logic                  wr_resp_q;
  logic                  wr_accept;
  logic                  wb_hit;
  logic                  rd_bmem_read;
  logic [ADDR_WIDTH-1:0] rd_bmem_addr;

  burst_wb_state_t       wb_state;
  logic                  wb_valid;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [LINE_WIDTH-1:0] wb_line;
  logic                  wb_bmem_write;
  logic [ADDR_WIDTH-1:0] wb_bmem_addr;
  logic [BEAT_WIDTH-1:0] wb_bmem_wdata;

  // Writes are only taken while no read is in flight so the two bus masters never overlap.
  assign wr_accept = l2cache_write && (wb_state == WB_EMPTY) && (rd_state_q == RD_IDLE);
  assign wb_hit    = wb_valid && ((l2cache_addr & ~OFF_MASK) == (wb_addr & ~OFF_MASK));

  burst_line_serializer #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LINE_WIDTH (LINE_WIDTH),
    .BEAT_WIDTH (BEAT_WIDTH)
  ) u_serializer (
    .clk          (clk),
    .rst          (rst),
    .load_i       (wr_accept),
    .addr_i       (l2cache_addr),
    .line_i       (l2cache_wdata),
    .bmem_ready_i (bmem_ready),
    .state_o      (wb_state),
    .valid_o      (wb_valid),
    .addr_o       (wb_addr),
    .line_o       (wb_line),
    .bmem_write_o (wb_bmem_write),
    .bmem_addr_o  (wb_bmem_addr),
    .bmem_wdata_o (wb_bmem_wdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_q <= RD_IDLE;
      rd_cnt_q   <= '0;
      rd_line_q  <= '0;
      wr_resp_q  <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_line_q  <= rd_line_d;
      wr_resp_q  <= wr_accept;
    end
  end

  always_comb begin
    rd_state_d   = rd_state_q;
    rd_cnt_d     = rd_cnt_q;
    rd_line_d    = rd_line_q;
    rd_bmem_read = 1'b0;
    rd_bmem_addr = '0;
    case (rd_state_q)
      RD_IDLE: begin
        if (l2cache_read) begin
          if (wb_state == WB_DRAIN) begin
            // A miss waits here so the pending write reaches memory first.
            if (wb_hit) begin
              rd_line_d  = wb_line;
              rd_state_d = RD_DONE;
            end
          end else begin
            rd_state_d = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        rd_bmem_read = 1'b1;
        rd_bmem_addr = l2cache_addr;
        if (bmem_ready) begin
          rd_state_d = RD_FILL;
          rd_cnt_d   = '0;
        end
      end
      RD_FILL: begin
        if (bmem_rvalid && (bmem_raddr == l2cache_addr)) begin
          rd_line_d[int'(rd_cnt_q) * BEAT_WIDTH +: BEAT_WIDTH] = bmem_rdata;
          rd_cnt_d = rd_cnt_q + CNT_W'(1);
          if (rd_cnt_q == LAST_BEAT) rd_state_d = RD_DONE;
        end
      end
      RD_DONE: rd_state_d = RD_IDLE;
      default: rd_state_d = RD_IDLE;
    endcase
  end

  assign bmem_read     = rd_bmem_read;
  assign bmem_write    = wb_bmem_write;
  assign bmem_addr     = wb_bmem_write ? wb_bmem_addr : rd_bmem_addr;
  assign bmem_wdata    = wb_bmem_wdata;
  assign l2cache_rdata = rd_line_q;
  assign l2cache_resp  = wr_resp_q || (rd_state_q == RD_DONE);

endmodule
